// File: rtl/robo_pkg.sv
// Shared encodings for the robot move path: command codes, headings,
// arbitration grant identities and the move-arbiter FSM states.
package robo_pkg;

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_FORWARD = 3'd1;
  localparam logic [2:0] CMD_TURN    = 3'd2;
  localparam logic [2:0] CMD_REMOVE  = 3'd3;
  localparam logic [2:0] CMD_UP      = 3'd4;
  localparam logic [2:0] CMD_DOWN    = 3'd5;
  localparam logic [2:0] CMD_LEFT    = 3'd6;
  localparam logic [2:0] CMD_RIGHT   = 3'd7;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam logic GRANT_GP = 1'b0;
  localparam logic GRANT_RB = 1'b1;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_ARB_ENC  = 2'd1;
  localparam logic [1:0] ST_EXEC_ENC = 2'd2;
  localparam logic [1:0] ST_HOLD_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_ARB  = ST_ARB_ENC,
    ST_EXEC = ST_EXEC_ENC,
    ST_HOLD = ST_HOLD_ENC
  } state_t;

  // FORWARD and the four absolute-direction codes (4..7) all attempt a step.
  function automatic logic is_move(input logic [2:0] cmd);
    return (cmd == CMD_FORWARD) || cmd[2];
  endfunction

endpackage

// File: rtl/move_arbiter_if.sv
// Request/acknowledge channels from the gamepad and the robot controller
// towards the move arbiter.
interface move_arbiter_if;
  logic       gp_req;
  logic [2:0] gp_cmd;
  logic       gp_ack;
  logic       rb_req;
  logic [2:0] rb_cmd;
  logic       rb_ack;

  modport master (output gp_req, gp_cmd, rb_req, rb_cmd, input gp_ack, rb_ack);
  modport slave  (input gp_req, gp_cmd, rb_req, rb_cmd, output gp_ack, rb_ack);
endinterface

// File: rtl/move_calc.sv
// Combinational next-heading / next-cell computation with grid edge check.
module move_calc
  import robo_pkg::*;
#(
  parameter int GRID_LINHAS  = 20,
  parameter int GRID_COLUNAS = 20
) (
  input  logic [4:0] i_linha,
  input  logic [4:0] i_coluna,
  input  logic [1:0] i_dir,
  input  logic [2:0] i_cmd,
  output logic [4:0] o_linha,
  output logic [4:0] o_coluna,
  output logic [1:0] o_dir,
  output logic       o_blocked
);

  logic [1:0] w_dir;
  logic       w_move;
  logic       w_edge;

  always_comb begin
    w_dir    = i_dir;
    w_move   = is_move(i_cmd);
    w_edge   = 1'b0;
    o_linha  = i_linha;
    o_coluna = i_coluna;

    case (i_cmd)
      CMD_TURN:  w_dir = i_dir + 2'd1;
      CMD_UP:    w_dir = DIR_UP;
      CMD_DOWN:  w_dir = DIR_DOWN;
      CMD_LEFT:  w_dir = DIR_LEFT;
      CMD_RIGHT: w_dir = DIR_RIGHT;
      default:   w_dir = i_dir;
    endcase

    // The step is taken along the heading that results from this command.
    case (w_dir)
      DIR_UP:   w_edge = (i_linha == 5'd0);
      DIR_DOWN: w_edge = (int'(i_linha) >= GRID_LINHAS - 1);
      DIR_LEFT: w_edge = (i_coluna == 5'd0);
      default:  w_edge = (int'(i_coluna) >= GRID_COLUNAS - 1);
    endcase

    if (w_move && !w_edge) begin
      case (w_dir)
        DIR_UP:   o_linha  = i_linha - 5'd1;
        DIR_DOWN: o_linha  = i_linha + 5'd1;
        DIR_LEFT: o_coluna = i_coluna - 5'd1;
        default:  o_coluna = i_coluna + 5'd1;
      endcase
    end

    o_dir     = w_dir;
    o_blocked = w_move & w_edge;
  end

endmodule

// File: rtl/move_arbiter.sv
// Frame-paced arbiter between gamepad and robot controller: at most one
// command per video frame, round-robin on ties, registered robot pose.
module move_arbiter
  import robo_pkg::*;
#(
  parameter int GRID_LINHAS  = 20,
  parameter int GRID_COLUNAS = 20,
  parameter int INI_LINHA    = 0,
  parameter int INI_COLUNA   = 0
) (
  input  logic       Clock50,
  input  logic       Reset,
  input  logic       v_sync,
  input  logic       gp_req,
  input  logic [2:0] gp_cmd,
  input  logic       rb_req,
  input  logic [2:0] rb_cmd,
  output logic       gp_ack,
  output logic       rb_ack,
  output logic [4:0] LinhaRobo,
  output logic [4:0] ColunaRobo,
  output logic [1:0] Direcao,
  output logic       remove,
  output logic       blocked,
  output logic [7:0] MoveCount
);

  state_t     r_state;
  state_t     w_state_next;
  logic       r_vsync;
  logic       r_vsync_prev;
  logic       r_last_grant;
  logic       r_win;
  logic [2:0] r_cmd;
  logic [4:0] r_linha;
  logic [4:0] r_coluna;
  logic [1:0] r_dir;
  logic [7:0] r_count;
  logic       r_gp_ack;
  logic       r_rb_ack;
  logic       r_remove;
  logic       r_blocked;

  logic       w_frame_start;
  logic       w_any_req;
  logic       w_win;
  logic [4:0] w_linha_next;
  logic [4:0] w_coluna_next;
  logic [1:0] w_dir_next;
  logic       w_blocked;

  assign w_frame_start = r_vsync_prev & ~r_vsync;
  assign w_any_req     = gp_req | rb_req;
  // Robot wins when alone, or on a tie when the gamepad had the last grant.
  assign w_win = (rb_req && (!gp_req || r_last_grant == GRANT_GP)) ? GRANT_RB : GRANT_GP;

  move_calc #(
    .GRID_LINHAS (GRID_LINHAS),
    .GRID_COLUNAS(GRID_COLUNAS)
  ) u_calc (
    .i_linha  (r_linha),
    .i_coluna (r_coluna),
    .i_dir    (r_dir),
    .i_cmd    (r_cmd),
    .o_linha  (w_linha_next),
    .o_coluna (w_coluna_next),
    .o_dir    (w_dir_next),
    .o_blocked(w_blocked)
  );

  always_ff @(posedge Clock50) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_frame_start) w_state_next = ST_ARB;
      ST_ARB:  w_state_next = w_any_req ? ST_EXEC : ST_IDLE;
      ST_EXEC: w_state_next = ST_HOLD;
      ST_HOLD: if (r_vsync) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock50) begin
    if (Reset) begin
      r_vsync      <= 1'b1;
      r_vsync_prev <= 1'b1;
      r_last_grant <= GRANT_RB;
      r_win        <= GRANT_GP;
      r_cmd        <= CMD_NOP;
      r_linha      <= 5'(INI_LINHA);
      r_coluna     <= 5'(INI_COLUNA);
      r_dir        <= DIR_UP;
      r_count      <= 8'd0;
      r_gp_ack     <= 1'b0;
      r_rb_ack     <= 1'b0;
      r_remove     <= 1'b0;
      r_blocked    <= 1'b0;
    end else begin
      r_vsync      <= v_sync;
      r_vsync_prev <= r_vsync;
      r_gp_ack     <= 1'b0;
      r_rb_ack     <= 1'b0;
      r_remove     <= 1'b0;
      r_blocked    <= 1'b0;
      // The winner's command is captured once; later changes are not seen.
      if (r_state == ST_ARB && w_any_req) begin
        r_cmd        <= (w_win == GRANT_RB) ? rb_cmd : gp_cmd;
        r_win        <= w_win;
        r_last_grant <= w_win;
      end
      if (r_state == ST_EXEC) begin
        r_linha   <= w_linha_next;
        r_coluna  <= w_coluna_next;
        r_dir     <= w_dir_next;
        r_count   <= r_count + 8'd1;
        r_gp_ack  <= (r_win == GRANT_GP);
        r_rb_ack  <= (r_win == GRANT_RB);
        r_remove  <= (r_cmd == CMD_REMOVE);
        r_blocked <= w_blocked;
      end
    end
  end

  assign gp_ack     = r_gp_ack;
  assign rb_ack     = r_rb_ack;
  assign LinhaRobo  = r_linha;
  assign ColunaRobo = r_coluna;
  assign Direcao    = r_dir;
  assign remove     = r_remove;
  assign blocked    = r_blocked;
  assign MoveCount  = r_count;

endmodule

// File: tb/tb_move_arbiter.sv
// Directed bench for move_arbiter: an expectation is queued per command
// issued and checked against each acknowledge the arbiter produces.
module tb_move_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs  = 1'b1;
  logic [4:0] linha;
  logic [4:0] coluna;
  logic [1:0] dir;
  logic       remove_o;
  logic       blocked_o;
  logic [7:0] count;

  always #5 clk = ~clk;

  move_arbiter_if u_if ();

  move_arbiter #(
    .GRID_LINHAS (20),
    .GRID_COLUNAS(20),
    .INI_LINHA   (0),
    .INI_COLUNA  (0)
  ) dut (
    .Clock50   (clk),
    .Reset     (rst),
    .v_sync    (vs),
    .gp_req    (u_if.gp_req),
    .gp_cmd    (u_if.gp_cmd),
    .rb_req    (u_if.rb_req),
    .rb_cmd    (u_if.rb_cmd),
    .gp_ack    (u_if.gp_ack),
    .rb_ack    (u_if.rb_ack),
    .LinhaRobo (linha),
    .ColunaRobo(coluna),
    .Direcao   (dir),
    .remove    (remove_o),
    .blocked   (blocked_o),
    .MoveCount (count)
  );

  typedef struct {
    bit rb;
    int l;
    int c;
    int d;
    int n;
    bit rem;
    bit blk;
  } exp_t;

  exp_t sb_q[$];
  int   m_l = 0, m_c = 0, m_d = 0, m_n = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   fall_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // Reference model: step deltas per heading, grid 20x20.
  task automatic push_cmd(input bit rb, input int cmd);
    int   nd;
    int   nl;
    int   nc;
    bit   mv;
    exp_t e;
    nd = m_d; nl = m_l; nc = m_c; mv = 1'b1;
    case (cmd)
      1: ;
      2: begin nd = (m_d + 1) % 4; mv = 1'b0; end
      4: nd = 0;
      5: nd = 2;
      6: nd = 3;
      7: nd = 1;
      default: mv = 1'b0;
    endcase
    if (mv) begin
      if (nd == 0) nl = nl - 1;
      else if (nd == 2) nl = nl + 1;
      else if (nd == 1) nc = nc + 1;
      else nc = nc - 1;
    end
    e.blk = mv && (nl < 0 || nl > 19 || nc < 0 || nc > 19);
    if (!e.blk) begin m_l = nl; m_c = nc; end
    m_d   = nd;
    m_n   = (m_n + 1) % 256;
    e.rb  = rb;
    e.l   = m_l;
    e.c   = m_c;
    e.d   = m_d;
    e.n   = m_n;
    e.rem = (cmd == 3);
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (u_if.gp_ack || u_if.rb_ack || remove_o || blocked_o) begin
      chk("ack_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        $display("txn %s row=%0d col=%0d dir=%0d cnt=%0d rem=%0d blk=%0d",
                 e.rb ? "rb" : "gp", linha, coluna, dir, count, remove_o, blocked_o);
        chk("gp_ack",  32'(u_if.gp_ack), 32'(!e.rb));
        chk("rb_ack",  32'(u_if.rb_ack), 32'(e.rb));
        chk("row",     32'(linha), e.l);
        chk("col",     32'(coluna), e.c);
        chk("dir",     32'(dir), e.d);
        chk("count",   32'(count), e.n);
        chk("remove",  32'(remove_o), 32'(e.rem));
        chk("blocked", 32'(blocked_o), 32'(e.blk));
        chk("latency", cyc - fall_cyc, 32'd4);
      end
    end
  end

  // One v_sync frame; optional request drop, mid-frame glitch and reset pulse.
  task automatic frame(input int drop_at, input bit glitch, input int rst_at);
    @(negedge clk);
    fall_cyc = cyc;
    vs = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (glitch) begin
        if (k == 1) vs = 1'b1;
        if (k == 3) vs = 1'b0;
        if (k == 8) vs = 1'b1;
      end else if (k == 3) begin
        vs = 1'b1;
      end
      if (k == drop_at) begin u_if.gp_req = 1'b0; u_if.rb_req = 1'b0; end
      if (k == rst_at) rst = 1'b1;
      if (k == rst_at + 1) rst = 1'b0;
    end
    chk("drain", sb_q.size(), 32'd0);
    sb_q.delete();
  endtask

  task automatic do_reset();
    u_if.gp_req = 1'b0;
    u_if.rb_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_l = 0; m_c = 0; m_d = 0; m_n = 0;
  endtask

  initial begin
    u_if.gp_req = 1'b0; u_if.gp_cmd = 3'd0;
    u_if.rb_req = 1'b0; u_if.rb_cmd = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_row", 32'(linha), 32'd0);
    chk("rst_col", 32'(coluna), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_acks", 32'({u_if.gp_ack, u_if.rb_ack}), 32'd0);
    chk("rst_pulses", 32'({remove_o, blocked_o}), 32'd0);

    // Gamepad RIGHT from the origin
    u_if.gp_req = 1'b1; u_if.gp_cmd = 3'd7;
    push_cmd(0, 7); frame(-1, 0, -1);
    u_if.gp_req = 1'b0;

    // Robot FORWARD heading up from row 0 is blocked
    do_reset();
    u_if.rb_req = 1'b1; u_if.rb_cmd = 3'd1;
    push_cmd(1, 1); frame(-1, 0, -1);
    u_if.rb_req = 1'b0;

    // Both held for three frames: gp, rb, gp
    do_reset();
    u_if.gp_req = 1'b1; u_if.gp_cmd = 3'd5;
    u_if.rb_req = 1'b1; u_if.rb_cmd = 3'd2;
    push_cmd(0, 5); frame(-1, 0, -1);
    push_cmd(1, 2); frame(-1, 0, -1);
    push_cmd(0, 5); frame(-1, 0, -1);
    u_if.gp_req = 1'b0; u_if.rb_req = 1'b0;
    chk("rr_count", 32'(count), 32'd3);

    // Second falling edge while in HOLD must not re-execute
    u_if.gp_req = 1'b1; u_if.gp_cmd = 3'd7;
    push_cmd(0, 7); frame(-1, 1, -1);
    u_if.gp_req = 1'b0;

    // Four TURNs from heading up
    do_reset();
    u_if.rb_req = 1'b1; u_if.rb_cmd = 3'd2;
    repeat (4) begin push_cmd(1, 2); frame(-1, 0, -1); end
    u_if.rb_req = 1'b0;

    // Edges, REMOVE and NOP
    do_reset();
    u_if.rb_req = 1'b1; u_if.rb_cmd = 3'd6;
    push_cmd(1, 6); frame(-1, 0, -1);
    u_if.rb_req = 1'b0;
    u_if.gp_req = 1'b1; u_if.gp_cmd = 3'd3;
    push_cmd(0, 3); frame(-1, 0, -1);
    u_if.gp_cmd = 3'd0;
    push_cmd(0, 0); frame(-1, 0, -1);
    u_if.gp_cmd = 3'd5;
    repeat (20) begin push_cmd(0, 5); frame(-1, 0, -1); end
    u_if.gp_req = 1'b0;
    u_if.rb_req = 1'b1; u_if.rb_cmd = 3'd7;
    repeat (20) begin push_cmd(1, 7); frame(-1, 0, -1); end
    u_if.rb_req = 1'b0;

    // Request withdrawn before arbitration is ignored
    u_if.gp_req = 1'b1; u_if.gp_cmd = 3'd4;
    repeat (2) @(negedge clk);
    u_if.gp_req = 1'b0;
    frame(-1, 0, -1);
    // Request withdrawn after arbitration still executes
    u_if.gp_req = 1'b1; u_if.gp_cmd = 3'd6;
    push_cmd(0, 6); frame(3, 0, -1);

    // Reset while in EXEC suppresses the command
    u_if.gp_req = 1'b1; u_if.gp_cmd = 3'd5;
    frame(-1, 0, 3);
    u_if.gp_req = 1'b0;
    m_l = 0; m_c = 0; m_d = 0; m_n = 0;
    chk("rexec_row", 32'(linha), 32'd0);
    chk("rexec_col", 32'(coluna), 32'd0);
    chk("rexec_dir", 32'(dir), 32'd0);
    chk("rexec_count", 32'(count), 32'd0);

    // MoveCount wraps after 256 commands
    u_if.rb_req = 1'b1; u_if.rb_cmd = 3'd0;
    repeat (256) begin push_cmd(1, 0); frame(-1, 0, -1); end
    u_if.rb_req = 1'b0;
    chk("wrap_count", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/move_arbiter.md
MOVE_ARBITER -- requirements
Module: move_arbiter

Interface
REQ-001 SHALL have parameters: GRID_LINHAS, default 20, number of grid rows; GRID_COLUNAS, default 20, number of grid columns; INI_LINHA, default 0, reset row; INI_COLUNA, default 0, reset column.
REQ-002 SHALL have ports (name, direction, width, meaning):
- Clock50  in  1  sole clock; one clock, all logic rising-edge.
- Reset  in  1  synchronous, active-high reset.
- v_sync  in  1  VGA vertical sync, active low; its falling edge marks frame start.
- gp_req  in  1  gamepad move request; held until gp_ack.
- gp_cmd  in  3  gamepad command code.
- rb_req  in  1  robot-controller move request; held until rb_ack.
- rb_cmd  in  3  robot command code.
- gp_ack  out  1  one-cycle grant/completion pulse to gamepad.
- rb_ack  out  1  one-cycle grant/completion pulse to robot.
- LinhaRobo  out  5  robot grid row.
- ColunaRobo  out  5  robot grid column.
- Direcao  out  2  heading: 0 up, 1 right, 2 down, 3 left.
- remove  out  1  one-cycle pulse: remove object at current cell.
- blocked  out  1  one-cycle pulse: move rejected at grid edge.
- MoveCount  out  8  count of executed commands.

Function
REQ-003 SHALL use command codes: 0 NOP, 1 FORWARD, 2 TURN, 3 REMOVE, 4 UP, 5 DOWN, 6 LEFT, 7 RIGHT.
REQ-004 SHALL register v_sync each cycle; frame_start SHALL be true when the previous sample is 1 and the current sample is 0.
REQ-005 SHALL implement FSM states IDLE, ARB, EXEC, HOLD: IDLE->ARB on frame_start; ARB->EXEC when any request is pending, else ARB->IDLE; EXEC->HOLD unconditionally; HOLD->IDLE when the registered v_sync is 1.
REQ-006 SHALL execute at most one command per frame; frame_start outside IDLE SHALL be ignored.
REQ-007 In ARB: a single requester SHALL win; on simultaneous requests the winner SHALL be the requester not granted last (round-robin); last_grant SHALL reset to robot, so the gamepad wins the first tie.
REQ-008 SHALL latch the winner's command in ARB; the command is not re-sampled after that.
REQ-009 Timing: clock edge E0 detects frame_start; E1 enters ARB; E2 enters EXEC; at E3, position, Direcao, MoveCount, the ack pulse and any remove/blocked pulse SHALL update together; acks SHALL be high exactly one cycle.
REQ-010 FORWARD SHALL move one cell along Direcao.
REQ-011 TURN SHALL set Direcao to (Direcao+1) mod 4 without moving.
REQ-012 UP/DOWN/LEFT/RIGHT SHALL set Direcao to 0/2/3/1, then move one cell.
REQ-013 REMOVE SHALL pulse remove with no position change.
REQ-014 A move leaving row 0..GRID_LINHAS-1 or column 0..GRID_COLUNAS-1 SHALL leave the position unchanged and pulse blocked; Direcao SHALL still update; ack still SHALL pulse.
REQ-015 NOP SHALL be acked with no state change other than MoveCount.
REQ-016 MoveCount SHALL increment by 1 per ack, wrapping 255->0.
REQ-017 A loser request SHALL stay pending and SHALL NOT be acked in the same frame.
REQ-018 A request dropped before ARB SHALL be ignored; a request dropped after ARB SHALL still execute.

Reset
REQ-019 On Reset high at a clock edge: state IDLE, LinhaRobo=INI_LINHA, ColunaRobo=INI_COLUNA, Direcao=0, MoveCount=0, all pulses 0, last_grant=robot, v_sync sample=1.
REQ-020 Reset SHALL take priority over every transition; reset during EXEC SHALL suppress that command's update and ack.

Structure
REQ-021 Command codes, direction encodings and FSM state encodings SHALL be localparams in shared package robo_pkg, reused by Gamepad and TemporizadorEntradas.
REQ-022 Boundary check and next-position computation SHALL be a combinational sub-module move_calc (inputs: position, direction, command; outputs: next position, next direction, blocked).

Verification
REQ-023 Reset, then one frame with gp_req=1, gp_cmd=7 -> at E3: ColunaRobo=1, Direcao=1, gp_ack pulse, MoveCount=1.
REQ-024 From (0,0), robot request FORWARD with Direcao=0 -> blocked pulse, position (0,0), rb_ack pulse.
REQ-025 Both requests held for 3 frames -> acks in order gp, rb, gp; MoveCount=3.
REQ-026 Second v_sync falling edge while in HOLD (glitch) -> no second execution in that frame.
REQ-027 Robot TURN issued 4 times across 4 frames -> Direcao sequence 1, 2, 3, 0; position unchanged.
REQ-028 Reset asserted in EXEC with gp_cmd=5 -> no gp_ack, position = (INI_LINHA, INI_COLUNA), MoveCount=0.
